shift_right_sequential: RTL and testbench

SHIFT_RIGHT_SEQUENTIAL -- requirements
Module: shift_right_sequential

---
 rtl/shift_right_sequential.sv | 95 +++++++++
 tb/tb_shift_right_sequential.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shift_right_sequential.sv
// Multi-cycle 32-bit right shifter (logical or arithmetic) with valid/ready handshakes.
// Each BUSY cycle applies one binary-weighted stage (1,2,4,8,16) selected by the latched shift amount.
module shift_right_sequential #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic                 arith,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out
);

  localparam int SW = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [N-1:0]  data_reg, data_next;
  logic [SW-1:0] shamt_reg, shamt_next;
  logic          arith_reg, arith_next;
  logic [2:0]    step_reg, step_next;

  // With sign fill the MSB of data_reg always equals the original operand's sign.
  logic          fill;
  logic [N-1:0]  stage [SW];

  assign fill = arith_reg & data_reg[N-1];

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_stage
      localparam int AMT = 1 << gi;
      assign stage[gi] = fill ? ~((~data_reg) >> AMT) : (data_reg >> AMT);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    shamt_next = shamt_reg;
    arith_next = arith_reg;
    step_next  = step_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next  = in;
          shamt_next = shamt;
          arith_next = arith;
          step_next  = 3'd0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (step_reg == 3'(SW)) begin
          state_next = DONE;
        end else begin
          if (shamt_reg[step_reg]) data_next = stage[step_reg];
          step_next = step_reg + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      shamt_reg <= '0;
      arith_reg <= 1'b0;
      step_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      shamt_reg <= shamt_next;
      arith_reg <= arith_next;
      step_reg  <= step_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out       = data_reg;

endmodule

// File: tb/tb_shift_right_sequential.sv
// Directed and random checks of shift_right_sequential: results, latency, backpressure, reset.
module tb_shift_right_sequential;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  shift_right_sequential #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .shamt(shamt), .arith(arith), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand from IDLE and waits for out_valid; reports edges from accept to out_valid.
  task automatic start_and_wait(input logic [31:0] a, input logic [4:0] s, input logic ar,
                                output logic [31:0] res, output int lat);
    in = a; shamt = s; arith = ar; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in = 32'hDEADBEEF; shamt = 5'd7; arith = ~ar;
    lat = 0;
    res = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
    res = out;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in = 32'hFFFFFFFF; shamt = 5'd3; arith = 1'b1; out_ready = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=00000000", out); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_no_accept got=%0b want=1", in_ready); end
    $display("reset: in_ready=%0b out_valid=%0b out=%h", in_ready, out_valid, out);
  endtask

  task automatic test_directed();
    logic [31:0] a [5] = '{32'h80000000, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678};
    logic [4:0]  s [5] = '{5'd31, 5'd31, 5'd4, 5'd4, 5'd0};
    logic        ar[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] e [5] = '{32'h00000001, 32'hFFFFFFFF, 32'hFF0F0F0F, 32'h0F0F0F0F, 32'h12345678};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_and_wait(a[i], s[i], ar[i], res, lat);
      total++; if (res !== e[i]) begin bad++; $display("FAIL directed_%0d_result got=%h want=%h", i, res, e[i]); end
      total++; if (lat !== 6) begin bad++; $display("FAIL directed_%0d_latency got=%0d want=6", i, lat); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL directed_%0d_in_ready got=%0b want=0", i, in_ready); end
      release_out();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL directed_%0d_to_idle out_valid=%0b in_ready=%0b want 0/1", i, out_valid, in_ready); end
      total++; if (out !== e[i]) begin bad++; $display("FAIL directed_%0d_idle_hold got=%h want=%h", i, out, e[i]); end
      $display("op in=%h shamt=%0d arith=%0b -> out=%h latency=%0d", a[i], s[i], ar[i], res, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    start_and_wait(32'hF0F0F0F0, 5'd4, 1'b1, res, lat);
    total++; if (res !== 32'hFF0F0F0F) begin bad++; $display("FAIL bp_result got=%h want=ff0f0f0f", res); end
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0); in = 32'h0000FFFF + i; shamt = 5'd1; arith = 1'b0; out_ready = 1'b0;
      tick();
      total++; if (out !== 32'hFF0F0F0F || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d out=%h out_valid=%0b in_ready=%0b want ff0f0f0f/1/0", i, out, out_valid, in_ready);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'hFF0F0F0F) begin
      bad++; $display("FAIL bp_release in_ready=%0b out_valid=%0b out=%h want 1/0/ff0f0f0f", in_ready, out_valid, out);
    end
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_stays got=%0b want=1", in_ready); end
    $display("backpressure: held 4 cycles out=%h", out);
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res;
    int lat;
    in = 32'hFFFF0000; shamt = 5'd7; arith = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'h0) begin
      bad++; $display("FAIL mid_reset in_ready=%0b out_valid=%0b out=%h want 1/0/00000000", in_ready, out_valid, out);
    end
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_settle in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
    start_and_wait(32'h80000010, 5'd4, 1'b1, res, lat);
    total++; if (res !== 32'hF8000001 || lat !== 6) begin
      bad++; $display("FAIL mid_reset_fresh got=%h lat=%0d want=f8000001 lat=6", res, lat);
    end
    release_out();
    $display("mid-busy reset then fresh op out=%h", res);
  endtask

  task automatic test_random();
    logic [31:0] a, res, exp_v;
    logic [4:0] s;
    logic ar;
    int lat, stall;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom; s = 5'($urandom_range(0, 31)); ar = 1'($urandom_range(0, 1));
      exp_v = ar ? 32'($signed(a) >>> s) : (a >> s);
      start_and_wait(a, s, ar, res, lat);
      total++; if (res !== exp_v || lat !== 6) begin
        bad++; $display("FAIL rand_%0d in=%h shamt=%0d arith=%0b got=%h lat=%0d want=%h lat=6", n, a, s, ar, res, lat, exp_v);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        in_valid = 1'($urandom_range(0, 1)); in = $urandom;
        tick();
        total++; if (out !== exp_v || out_valid !== 1'b1) begin
          bad++; $display("FAIL rand_stall_%0d got=%h out_valid=%0b want=%h/1", n, out, out_valid, exp_v);
        end
      end
      in_valid = 1'b0;
      release_out();
      $display("rand %0d in=%h shamt=%0d arith=%0b out=%h stall=%0d", n, a, s, ar, res, stall);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = '0; shamt = '0; arith = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
